// File: rtl/vga_timing_scope_if.sv
// Raster timing and trace-window bundle from vga_timing_scope to the drawing stages.
interface vga_timing_scope_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;
  logic        win_active;
  logic [8:0]  win_x;
  logic [8:0]  win_y;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk,
           frame_start, win_active, win_x, win_y
  );

  modport slave (
    input  hcount, vcount, hsync, vsync, hblnk, vblnk,
           frame_start, win_active, win_x, win_y
  );
endinterface

// File: rtl/vga_timing_scope.sv
// 800x600@60 raster counters, sync/blank strobes and scope-window decode.
// Every output is registered together with the counters, so all outputs describe one (h,v) pair.
module vga_timing_scope #(
  parameter int HOR_PIXELS = 800,
  parameter int VER_PIXELS = 600,
  parameter int H_DISPLAY  = 300,
  parameter int V_DISPLAY  = 300,
  parameter int WIN_X      = 250,
  parameter int WIN_Y      = 150
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_timing_scope_if.master  vga_o
);

  localparam int H_TOTAL = HOR_PIXELS + 40 + 128 + 88;
  localparam int V_TOTAL = VER_PIXELS + 1 + 4 + 23;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS   = 11'(HOR_PIXELS);
  localparam logic [10:0] HS_ON   = 11'(HOR_PIXELS + 40);
  localparam logic [10:0] HS_OFF  = 11'(HOR_PIXELS + 40 + 128 - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS   = 10'(VER_PIXELS);
  localparam logic [9:0]  VS_ON   = 10'(VER_PIXELS + 1);
  localparam logic [9:0]  VS_OFF  = 10'(VER_PIXELS + 4);
  localparam logic [10:0] WX_LO   = 11'(WIN_X);
  localparam logic [10:0] WX_HI   = 11'(WIN_X + H_DISPLAY);
  localparam logic [9:0]  WY_LO   = 10'(WIN_Y);
  localparam logic [9:0]  WY_HI   = 10'(WIN_Y + V_DISPLAY);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic        win_active_q, win_active_d;
  logic [8:0]  win_x_q, win_x_d;
  logic [8:0]  win_y_q, win_y_d;

  // Decodes look at the next counter values so they land in the same register stage.
  always_comb begin
    hcount_d = (hcount_q == H_LAST) ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end

    hblnk_d       = (hcount_d >= H_VIS);
    hsync_d       = (hcount_d >= HS_ON) && (hcount_d <= HS_OFF);
    vblnk_d       = (vcount_d >= V_VIS);
    vsync_d       = (vcount_d >= VS_ON) && (vcount_d <= VS_OFF);
    frame_start_d = (hcount_d == 11'd0) && (vcount_d == 10'd0);

    win_active_d  = (hcount_d >= WX_LO) && (hcount_d < WX_HI) &&
                    (vcount_d >= WY_LO) && (vcount_d < WY_HI);
    win_x_d = 9'd0;
    win_y_d = 9'd0;
    if (win_active_d) begin
      win_x_d = 9'(hcount_d - WX_LO);
      win_y_d = 9'(vcount_d - WY_LO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      win_active_q  <= 1'b0;
      win_x_q       <= '0;
      win_y_q       <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
      win_active_q  <= win_active_d;
      win_x_q       <= win_x_d;
      win_y_q       <= win_y_d;
    end
  end

  assign vga_o.hcount      = hcount_q;
  assign vga_o.vcount      = vcount_q;
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.hblnk       = hblnk_q;
  assign vga_o.vblnk       = vblnk_q;
  assign vga_o.frame_start = frame_start_q;
  assign vga_o.win_active  = win_active_q;
  assign vga_o.win_x       = win_x_q;
  assign vga_o.win_y       = win_y_q;

endmodule

// File: tb/tb_vga_timing_scope.sv
// Bench for vga_timing_scope: a full-size instance and a shrunken-raster instance, each
// tracked cycle by cycle against a reference raster model, plus directed timing checks.
module tb_vga_timing_scope;

  localparam int HP_B = 64;
  localparam int VP_B = 20;
  localparam int HD_B = 20;
  localparam int VD_B = 10;
  localparam int WX_B = 20;
  localparam int WY_B = 5;
  localparam int HT_A = 1056;
  localparam int VT_A = 628;
  localparam int HT_B = HP_B + 256;
  localparam int VT_B = VP_B + 28;
  localparam int FRAME_B = HT_B * VT_B;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, hb, vb, fs, wa;
    logic [8:0]  wx, wy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_scope_if ifa ();
  vga_timing_scope_if ifb ();

  vga_timing_scope dut_a (.clk(clk), .rst_n(rst_n), .vga_o(ifa));

  vga_timing_scope #(
    .HOR_PIXELS(HP_B), .VER_PIXELS(VP_B), .H_DISPLAY(HD_B),
    .V_DISPLAY(VD_B), .WIN_X(WX_B), .WIN_Y(WY_B)
  ) dut_b (.clk(clk), .rst_n(rst_n), .vga_o(ifb));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic obs_t model(int h, int v, int hp, int vp, int hd, int vd, int wx, int wy);
    obs_t o;
    o    = '0;
    o.h  = 11'(h);
    o.v  = 10'(v);
    o.hb = (h >= hp);
    o.hs = (h >= hp + 40) && (h < hp + 168);
    o.vb = (v >= vp);
    o.vs = (v > vp) && (v <= vp + 4);
    o.fs = (h == 0) && (v == 0);
    o.wa = (h >= wx) && (h < wx + hd) && (v >= wy) && (v < wy + vd);
    if (o.wa) begin
      o.wx = 9'(h - wx);
      o.wy = 9'(v - wy);
    end
    return o;
  endfunction

  function automatic obs_t get_a();
    obs_t o;
    o = '{ifa.hcount, ifa.vcount, ifa.hsync, ifa.vsync, ifa.hblnk, ifa.vblnk,
          ifa.frame_start, ifa.win_active, ifa.win_x, ifa.win_y};
    return o;
  endfunction

  function automatic obs_t get_b();
    obs_t o;
    o = '{ifb.hcount, ifb.vcount, ifb.hsync, ifb.vsync, ifb.hblnk, ifb.vblnk,
          ifb.frame_start, ifb.win_active, ifb.win_x, ifb.win_y};
    return o;
  endfunction

  // Scoreboard: the model advances on each clock edge and queues the expected outputs.
  int   mha, mva, mhb, mvb;
  bit   run = 1'b0;
  obs_t qa[$];
  obs_t qb[$];

  always @(posedge clk) begin
    if (run) begin
      if (mha == HT_A - 1) begin
        mha = 0;
        mva = (mva == VT_A - 1) ? 0 : mva + 1;
      end else mha = mha + 1;
      if (mhb == HT_B - 1) begin
        mhb = 0;
        mvb = (mvb == VT_B - 1) ? 0 : mvb + 1;
      end else mhb = mhb + 1;
      qa.push_back(model(mha, mva, 800, 600, 300, 300, 250, 150));
      qb.push_back(model(mhb, mvb, HP_B, VP_B, HD_B, VD_B, WX_B, WY_B));
    end
  end

  always @(negedge clk) begin
    if (qa.size() > 0) chk("sb_a", 64'(get_a()), 64'(qa.pop_front()));
    if (qb.size() > 0) chk("sb_b", 64'(get_b()), 64'(qb.pop_front()));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int hb_rise = -1, hs_cnt = 0, hs_lo = 9999, hs_hi = -1, wrap_v = -1, prev_h_a = -1;
  bit prev_hb_a = 1'b0, prev_vs_b = 1'b0;
  int fs_edges[$];
  int vs_cnt = 0, vs_lo = 9999, vs_hi = -1, vb_lo = 9999, vb_hi = -1;
  int vs_start_h = -1, vs_start_v = -1;
  int wa_cnt = 0, wa_blank = 0;
  logic [18:0] c0, c1, c2, c3;
  bit found, got;
  int fs_at;

  initial begin
    c0 = 'x; c1 = 'x; c2 = 'x; c3 = 'x;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("reset_a", 64'(get_a()), 64'd0);
    chk("reset_b", 64'(get_b()), 64'd0);

    mha = 0; mva = 0; mhb = 0; mvb = 0;
    run = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_h", 64'(ifa.hcount), 64'd1);
    chk("first_v", 64'(ifa.vcount), 64'd0);
    chk("first_strobes", 64'({ifa.hsync, ifa.vsync, ifa.hblnk, ifa.vblnk,
                              ifa.frame_start, ifa.win_active}), 64'd0);

    for (int i = 1; i <= 2 * FRAME_B; i++) begin
      @(negedge clk);
      if (i <= HT_A + 2) begin
        if (ifa.hblnk && !prev_hb_a && hb_rise < 0) hb_rise = int'(ifa.hcount);
        if (ifa.hsync) begin
          hs_cnt++;
          if (int'(ifa.hcount) < hs_lo) hs_lo = int'(ifa.hcount);
          if (int'(ifa.hcount) > hs_hi) hs_hi = int'(ifa.hcount);
        end
        if (prev_h_a == HT_A - 1 && ifa.hcount == 11'd0) wrap_v = int'(ifa.vcount);
        prev_hb_a = ifa.hblnk;
        prev_h_a  = int'(ifa.hcount);
      end
      if (ifb.frame_start) fs_edges.push_back(i);
      if (ifb.vsync) begin
        vs_cnt++;
        if (int'(ifb.vcount) < vs_lo) vs_lo = int'(ifb.vcount);
        if (int'(ifb.vcount) > vs_hi) vs_hi = int'(ifb.vcount);
        if (!prev_vs_b && vs_start_h < 0) begin
          vs_start_h = int'(ifb.hcount);
          vs_start_v = int'(ifb.vcount);
        end
      end
      prev_vs_b = ifb.vsync;
      if (ifb.vblnk) begin
        if (int'(ifb.vcount) < vb_lo) vb_lo = int'(ifb.vcount);
        if (int'(ifb.vcount) > vb_hi) vb_hi = int'(ifb.vcount);
      end
      if (ifb.win_active && i <= FRAME_B) wa_cnt++;
      if (ifb.win_active && (ifb.hblnk || ifb.vblnk)) wa_blank++;
      if (ifb.hcount == 11'(WX_B) && ifb.vcount == 10'(WY_B))
        c0 = {ifb.win_active, ifb.win_x, ifb.win_y};
      if (ifb.hcount == 11'(WX_B + HD_B - 1) && ifb.vcount == 10'(WY_B + VD_B - 1))
        c1 = {ifb.win_active, ifb.win_x, ifb.win_y};
      if (ifb.hcount == 11'(WX_B - 1) && ifb.vcount == 10'(WY_B))
        c2 = {ifb.win_active, ifb.win_x, ifb.win_y};
      if (ifb.hcount == 11'(WX_B + HD_B) && ifb.vcount == 10'(WY_B + VD_B - 1))
        c3 = {ifb.win_active, ifb.win_x, ifb.win_y};
    end

    chk("hblnk_rise_h", 64'(hb_rise), 64'd800);
    chk("hsync_width",  64'(hs_cnt),  64'd128);
    chk("hsync_first_h", 64'(hs_lo),  64'd840);
    chk("hsync_last_h",  64'(hs_hi),  64'd967);
    chk("line_wrap_v",   64'(wrap_v), 64'd1);

    chk("frame_start_count", 64'(fs_edges.size()), 64'd2);
    chk("frame_start_first", 64'((fs_edges.size() > 0) ? fs_edges[0] : -1), 64'(FRAME_B));
    chk("frame_start_period",
        64'((fs_edges.size() > 1) ? fs_edges[1] - fs_edges[0] : -1), 64'(FRAME_B));
    chk("vsync_width",   64'(vs_cnt),     64'(2 * 4 * HT_B));
    chk("vsync_first_v", 64'(vs_lo),      64'(VP_B + 1));
    chk("vsync_last_v",  64'(vs_hi),      64'(VP_B + 4));
    chk("vsync_start_h", 64'(vs_start_h), 64'd0);
    chk("vsync_start_v", 64'(vs_start_v), 64'(VP_B + 1));
    chk("vblnk_first_v", 64'(vb_lo),      64'(VP_B));
    chk("vblnk_last_v",  64'(vb_hi),      64'(VT_B - 1));
    chk("win_population", 64'(wa_cnt),    64'(HD_B * VD_B));
    chk("win_in_blank",   64'(wa_blank),  64'd0);
    chk("corner_tl",      64'(c0), 64'({1'b1, 9'd0, 9'd0}));
    chk("corner_br",      64'(c1), 64'({1'b1, 9'(HD_B - 1), 9'(VD_B - 1)}));
    chk("corner_left_out",  64'(c2), 64'd0);
    chk("corner_right_out", 64'(c3), 64'd0);

    // Drop reset while inside both sync pulses.
    found = 1'b0;
    for (int i = 0; i < FRAME_B && !found; i++) begin
      @(negedge clk);
      if (ifb.vcount == 10'(VP_B + 2) && ifb.hcount == 11'(HP_B + 100)) found = 1'b1;
    end
    chk("midrst_reached", 64'(found), 64'd1);
    chk("midrst_syncs_before", 64'({ifb.hsync, ifb.vsync}), 64'd3);
    #2;
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_syncs_after", 64'({ifb.hsync, ifb.vsync}), 64'd0);
    chk("midrst_all_b", 64'(get_b()), 64'd0);
    chk("midrst_all_a", 64'(get_a()), 64'd0);
    qa.delete();
    qb.delete();

    @(negedge clk);
    mha = 0; mva = 0; mhb = 0; mvb = 0;
    run = 1'b1;
    rst_n = 1'b1;
    got = 1'b0;
    fs_at = -1;
    for (int i = 1; i <= FRAME_B + 2 && !got; i++) begin
      @(negedge clk);
      if (ifb.frame_start) begin
        got = 1'b1;
        fs_at = i;
      end
    end
    chk("midrst_next_frame_start", 64'(fs_at), 64'(FRAME_B));

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
